// File: rtl/mdu_iter_divider_pkg.sv
// Shared types and constants for the iterative divider.
// FSM encoding, counter sizing and divide-by-zero result.
package mdu_iter_divider_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [XLEN-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/mdu_iter_divider_clz.sv
// Count leading zeros of a 32-bit value.
// Returns 32 for an all-zero input.
module mdu_iter_divider_clz
  import mdu_iter_divider_pkg::*;
(
  input  logic [XLEN-1:0]  i_val,
  output logic [CNT_W-1:0] o_cnt
);

  // Highest set bit wins since the loop walks upward.
  always_comb begin
    o_cnt = CNT_W'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (i_val[i]) o_cnt = CNT_W'(XLEN - 1 - i);
    end
  end

endmodule

// File: rtl/mdu_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU, quotient -> LO, remainder -> HI.
// Leading zeros of the dividend magnitude are skipped when EARLY_OUT is set.
module mdu_iter_divider
  import mdu_iter_divider_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  raw_q, raw_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  rmo_q, rmo_d;
  logic             dz_q, dz_d;

  logic [CNT_W-1:0] clz;
  logic [CNT_W-1:0] z;
  logic [CNT_W-1:0] n_calc;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    rem_sub;
  logic             ge;

  mdu_iter_divider_clz u_clz (
    .i_val (dvd_q),
    .o_cnt (clz)
  );

  // Operand signs, early-out shift amount and one restoring step.
  always_comb begin
    a_neg   = i_signed & i_dividend[XLEN-1];
    b_neg   = i_signed & i_divisor[XLEN-1];
    z       = EARLY_OUT ? clz : '0;
    n_calc  = CNT_W'(XLEN) - z;
    rem_sh  = {rem_q, dvd_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    ge      = rem_sh >= {1'b0, dsr_q};
  end

  // Next-state and datapath control for IDLE -> PREP -> ITER -> FIX.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    raw_d   = raw_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rmo_d   = rmo_q;
    dz_d    = dz_q;
    if (state_q != ST_IDLE && i_cancel) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (i_start && !i_cancel) begin
            dvd_d   = a_neg ? -i_dividend : i_dividend;
            dsr_d   = b_neg ? -i_divisor : i_divisor;
            raw_d   = i_dividend;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            busy_d  = 1'b1;
            state_d = ST_PREP;
          end
        end
        ST_PREP: begin
          dvd_d   = dvd_q << z;
          n_d     = n_calc;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (dsr_q == '0 || n_calc == '0) ? ST_FIX : ST_ITER;
        end
        ST_ITER: begin
          dvd_d = {dvd_q[XLEN-2:0], ge};
          rem_d = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == n_q) state_d = ST_FIX;
        end
        ST_FIX: begin
          if (dsr_q == '0) begin
            quo_d = DIV_ZERO_QUOTIENT;
            rmo_d = raw_q;
            dz_d  = 1'b1;
          end else begin
            quo_d = negq_q ? -dvd_q : dvd_q;
            rmo_d = negr_q ? -rem_q : rem_q;
            dz_d  = 1'b0;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // All state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      raw_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      raw_q   <= raw_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rmo_q   <= rmo_d;
      dz_q    <= dz_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_quotient  = quo_q;
  assign o_remainder = rmo_q;
  assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_mdu_iter_divider.sv
// Directed bench for mdu_iter_divider.
// Hand-computed quotient/remainder/latency vectors plus control cases.
module tb_mdu_iter_divider;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_cancel;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_quotient;
  logic [31:0] o_remainder;
  logic        o_div_zero;

  int n_tests;
  int n_fail;

  mdu_iter_divider #(
    .WIDTH     (32),
    .EARLY_OUT (1'b1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_cancel    (i_cancel),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_div_zero  (o_div_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag,
                         input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eq,
                         input logic [31:0] er,
                         input logic edz,
                         input int elat);
    int lat;
    @(negedge i_clk);
    i_start    = 1'b1;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    chk({tag, ".busy0"}, 32'(o_busy), 32'd1);
    lat = 1;
    while (!o_done && lat < 60) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".q"}, o_quotient, eq);
    chk({tag, ".r"}, o_remainder, er);
    chk({tag, ".dz"}, 32'(o_div_zero), 32'(edz));
    chk({tag, ".busyd"}, 32'(o_busy), 32'd1);
    @(posedge i_clk);
    #1;
    chk({tag, ".done1"}, 32'(o_done), 32'd0);
    chk({tag, ".busy1"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int saw;
    n_tests    = 0;
    n_fail     = 0;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    i_cancel   = 1'b0;
    #12;
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.q", o_quotient, 32'd0);
    chk("rst.r", o_remainder, 32'd0);
    chk("rst.dz", 32'(o_div_zero), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_div("divu100_7", 1'b0, 32'd100, 32'd7,
            32'd14, 32'd2, 1'b0, 10);
    run_div("div-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 6);
    run_div("div7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 32'd1, 1'b0, 6);
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
            32'hFFFF_FFFF, 32'd0, 1'b0, 35);
    run_div("divu0_5", 1'b0, 32'd0, 32'd5,
            32'd0, 32'd0, 1'b0, 3);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 1'b0, 35);
    run_div("div_by0", 1'b1, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 3);

    // Asynchronous reset in the middle of an iteration.
    @(negedge i_clk);
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'hFFFF_FFFF;
    i_divisor  = 32'd1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(o_busy), 32'd0);
    chk("arst.done", 32'(o_done), 32'd0);
    chk("arst.q", o_quotient, 32'd0);
    chk("arst.r", o_remainder, 32'd0);
    chk("arst.dz", 32'(o_div_zero), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_div("divu1000_33", 1'b0, 32'd1000, 32'd33,
            32'd30, 32'd10, 1'b0, 13);
    run_div("div-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
            32'd14, 32'hFFFF_FFFE, 1'b0, 10);
    run_div("divu5_10", 1'b0, 32'd5, 32'd10,
            32'd0, 32'd5, 1'b0, 6);
    run_div("div100_7", 1'b1, 32'd100, 32'd7,
            32'd14, 32'd2, 1'b0, 10);

    // Cancel during ITER: no done, previous results held.
    @(negedge i_clk);
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'h1234_5678;
    i_divisor  = 32'd3;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_cancel = 1'b1;
    @(posedge i_clk);
    #1;
    i_cancel = 1'b0;
    chk("cancel.busy", 32'(o_busy), 32'd0);
    saw = 0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_done) saw = 1;
    end
    chk("cancel.nodone", 32'(saw), 32'd0);
    chk("cancel.q", o_quotient, 32'd14);
    chk("cancel.r", o_remainder, 32'd2);

    run_div("divu_1234", 1'b0, 32'h1234_5678, 32'd3,
            32'h0611_7228, 32'd0, 1'b0, 32);

    // Start pulsed while busy must be ignored.
    @(negedge i_clk);
    i_start    = 1'b1;
    i_signed   = 1'b0;
    i_dividend = 32'd1000;
    i_divisor  = 32'd33;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_start    = 1'b1;
    i_dividend = 32'd5;
    i_divisor  = 32'd10;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_done) saw++;
    end
    chk("ign.ndone", 32'(saw), 32'd1);
    chk("ign.q", o_quotient, 32'd30);
    chk("ign.r", o_remainder, 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
